// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and default width for the sequential ALU.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

endpackage

// File: rtl/seq_muldiv.sv
// Shared iterative engine: radix-2 Booth multiply or non-restoring signed divide,
// one step per clock for WIDTH clocks after load; result valid alongside step_done.
module seq_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             step_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH+1:0] acc, acc_n, sum, shl, rdiv, mext, dext;
  logic [WIDTH-1:0] q, q_n, m, rem;
  logic [SHW-1:0]   cnt;
  logic             q1, q1_n, active, mode_r, neg_q, neg_r;

  assign mext      = {{2{m[WIDTH-1]}}, m};
  assign dext      = {2'b00, m};
  assign step_done = active && (cnt == SHW'(WIDTH-1));

  always_comb begin
    acc_n = acc;
    q_n   = q;
    q1_n  = q1;
    sum   = acc;
    shl   = '0;
    rdiv  = '0;
    if (!mode_r) begin
      if ({q[0], q1} == 2'b01)      sum = acc + mext;
      else if ({q[0], q1} == 2'b10) sum = acc - mext;
      {acc_n, q_n, q1_n} = {sum[WIDTH+1], sum, q};
    end else begin
      // divide on magnitudes; acc is the signed partial remainder
      shl   = {acc[WIDTH:0], q[WIDTH-1]};
      rdiv  = acc[WIDTH+1] ? shl + dext : shl - dext;
      acc_n = rdiv;
      q_n   = {q[WIDTH-2:0], ~rdiv[WIDTH+1]};
    end
  end

  // final remainder correction and sign fix for the divide result
  assign rem = acc_n[WIDTH+1] ? acc_n[WIDTH-1:0] + m : acc_n[WIDTH-1:0];

  always_comb begin
    if (!mode_r) begin
      hi = acc_n[WIDTH-1:0];
      lo = q_n;
    end else begin
      hi = neg_r ? -rem : rem;
      lo = neg_q ? -q_n : q_n;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
      mode_r <= mode;
      acc    <= '0;
      q1     <= 1'b0;
      neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
      neg_r  <= a[WIDTH-1];
      if (mode) begin
        q <= a[WIDTH-1] ? -a : a;
        m <= b[WIDTH-1] ? -b : b;
      end else begin
        q <= a;
        m <= b;
      end
    end else if (active) begin
      acc <= acc_n;
      q   <= q_n;
      q1  <= q1_n;
      cnt <= cnt + 1'b1;
      if (step_done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MUL/DIV behind a
// start/done handshake, results held in the Z high/low registers.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] Zhighout,
  output logic [WIDTH-1:0] Zlowout
);

  state_t             state, state_n;
  logic               accept, load, step_done, div_zero;
  logic [WIDTH-1:0]   alu_res, hi, lo;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rol_full, ror_full;

  assign accept   = start && (state == IDLE);
  assign div_zero = (opcode == OP_DIV) && (B == '0);
  assign busy     = (state != IDLE);
  assign sh       = B[SHW-1:0];
  assign rol_full = {A, A} << sh;
  assign ror_full = {A, A} >> sh;

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_SHR:  alu_res = A >> sh;
      OP_SHRA: alu_res = $signed(A) >>> sh;
      OP_SHL:  alu_res = A << sh;
      OP_ROL:  alu_res = rol_full[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_res = ror_full[WIDTH-1:0];
      OP_NEG:  alu_res = -B;
      OP_NOT:  alu_res = ~B;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (opcode == OP_MUL) begin
          state_n = MUL;
          load    = 1'b1;
        end else if ((opcode == OP_DIV) && !div_zero) begin
          state_n = DIV;
          load    = 1'b1;
        end
      end
      MUL, DIV: if (step_done) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state       <= IDLE;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      Zhighout    <= '0;
      Zlowout     <= '0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (accept) begin
        div_by_zero <= 1'b0;
        if (div_zero) begin
          done        <= 1'b1;
          div_by_zero <= 1'b1;
          Zhighout    <= A;
          Zlowout     <= '1;
        end else if (!load) begin
          done     <= 1'b1;
          Zhighout <= '0;
          Zlowout  <= alu_res;
        end
      end else if (step_done) begin
        done     <= 1'b1;
        Zhighout <= hi;
        Zlowout  <= lo;
      end
    end
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .clear     (clear),
    .load      (load),
    .mode      (opcode == OP_DIV),
    .a         (A),
    .b         (B),
    .step_done (step_done),
    .hi        (hi),
    .lo        (lo)
  );

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: vector table with a result scoreboard, plus hand sequences
// for abort-by-reset, back-to-back accepts and a 16-bit multiply.
module tb_seq_alu;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
  } vec_t;

  logic        clock = 1'b0, clear = 1'b0, start = 1'b0;
  logic [4:0]  opcode = '0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] Zhighout, Zlowout;

  logic        s16 = 1'b0;
  logic [4:0]  op16 = '0;
  logic [15:0] A16 = '0, B16 = '0;
  logic        busy16, done16, dbz16;
  logic [15:0] hi16, lo16;

  int   n_vec = 0, n_fail = 0;
  exp_t sb[$];
  vec_t vt[$];

  always #5 clock = ~clock;

  seq_alu dut (
    .clock(clock), .clear(clear), .start(start), .opcode(opcode), .A(A), .B(B),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .Zhighout(Zhighout), .Zlowout(Zlowout)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clock(clock), .clear(clear), .start(s16), .opcode(op16), .A(A16), .B(B16),
    .busy(busy16), .done(done16), .div_by_zero(dbz16),
    .Zhighout(hi16), .Zlowout(lo16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] hi, input logic [31:0] lo,
                              input logic dbz, input int lat);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dbz = dbz; e.lat = lat;
    return e;
  endfunction

  // reference built from native arithmetic
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb_, p, qq, rr;
    logic [31:0] t;
    sa = $signed(a);
    sb_ = $signed(b);
    e = mk(32'h0, 32'h0, 1'b0, 1);
    case (op)
      OP_AND:  e.lo = a & b;
      OP_OR:   e.lo = a | b;
      OP_ADD:  e.lo = a + b;
      OP_SUB:  e.lo = a - b;
      OP_SHL:  e.lo = a << b[4:0];
      OP_SHR:  e.lo = a >> b[4:0];
      OP_SHRA: e.lo = $signed(a) >>> b[4:0];
      OP_ROL:  begin t = a; for (int i = 0; i < int'(b[4:0]); i++) t = {t[30:0], t[31]}; e.lo = t; end
      OP_ROR:  begin t = a; for (int i = 0; i < int'(b[4:0]); i++) t = {t[0], t[31:1]}; e.lo = t; end
      OP_NEG:  e.lo = -b;
      OP_NOT:  e.lo = ~b;
      OP_MUL:  begin p = sa * sb_; e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 33; end
      OP_DIV:
        if (b == 32'h0) begin
          e.hi = a; e.lo = 32'hFFFFFFFF; e.dbz = 1'b1;
        end else begin
          qq = sa / sb_; rr = sa % sb_;
          e.hi = rr[31:0]; e.lo = qq[31:0]; e.lat = 33;
        end
      default: ;
    endcase
    return e;
  endfunction

  task automatic run(input string name, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input exp_t e);
    int   cyc, bc;
    exp_t x;
    @(negedge clock);
    start = 1'b1; opcode = op; A = a; B = b;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0; A = $urandom; B = $urandom; opcode = 5'(OP_AND);
    cyc = 1; bc = 0;
    while (!done && cyc < 200) begin
      if (busy) bc++;
      @(negedge clock);
      cyc++;
    end
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end
    x = sb.pop_front();
    chk({name, " hi"},   64'(Zhighout),    64'(x.hi));
    chk({name, " lo"},   64'(Zlowout),     64'(x.lo));
    chk({name, " dbz"},  64'(div_by_zero), 64'(x.dbz));
    chk({name, " lat"},  64'(cyc),         64'(x.lat));
    chk({name, " busy"}, 64'(bc),          64'(x.lat - 1));
  endtask

  initial begin
    int cyc, bc;
    // table: spec vectors with fixed expectations, then model-derived ones
    vt.push_back('{OP_AND,  32'hF0F01234, 32'h0FF0FFFF, mk(32'h0, 32'h00F01234, 1'b0, 1)});
    vt.push_back('{OP_MUL,  32'hFFFFFFF9, 32'd6,        mk(32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33)});
    vt.push_back('{OP_DIV,  32'hFFFFFFEF, 32'd5,        mk(32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33)});
    vt.push_back('{OP_DIV,  32'h00001234, 32'd0,        mk(32'h00001234, 32'hFFFFFFFF, 1'b1, 1)});
    vt.push_back('{OP_ROL,  32'h80000001, 32'd4,        mk(32'h0, 32'h00000018, 1'b0, 1)});
    vt.push_back('{OP_ROR,  32'h80000001, 32'd1,        mk(32'h0, 32'hC0000000, 1'b0, 1)});
    vt.push_back('{OP_SHRA, 32'h80000000, 32'd35,       mk(32'h0, 32'hF0000000, 1'b0, 1)});
    vt.push_back('{OP_DIV,  32'h80000000, 32'hFFFFFFFF, mk(32'h0, 32'h80000000, 1'b0, 33)});
    begin
      logic [4:0]  ops[12];
      logic [31:0] ra, rb;
      ops = '{OP_OR, OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_SHRA, OP_ROL, OP_ROR,
              OP_NEG, OP_NOT, 5'b11111, OP_MUL};
      for (int i = 0; i < 12; i++) begin
        ra = $urandom; rb = $urandom;
        vt.push_back('{ops[i], ra, rb, model(ops[i], ra, rb)});
      end
      vt.push_back('{OP_MUL, 32'h80000000, 32'h80000000, model(OP_MUL, 32'h80000000, 32'h80000000)});
      vt.push_back('{OP_DIV, 32'd7, 32'hFFFFFFFE, model(OP_DIV, 32'd7, 32'hFFFFFFFE)});
      for (int i = 0; i < 4; i++) begin
        ra = $urandom; rb = $urandom >> (i * 7);
        vt.push_back('{OP_MUL, ra, rb, model(OP_MUL, ra, rb)});
        vt.push_back('{OP_DIV, ra, rb, model(OP_DIV, ra, rb)});
      end
    end

    // reset state
    repeat (2) @(negedge clock);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset dbz",  64'(div_by_zero), 64'd0);
    chk("reset hi",   64'(Zhighout), 64'd0);
    chk("reset lo",   64'(Zlowout), 64'd0);
    clear = 1'b1;

    foreach (vt[i]) run($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].e);

    // back-to-back single-cycle ops accepted in the done cycle
    @(negedge clock);
    start = 1'b1; opcode = OP_ADD; A = 32'd1; B = 32'd2;
    @(negedge clock);
    chk("b2b done1", 64'(done), 64'd1);
    chk("b2b lo1",   64'(Zlowout), 64'd3);
    opcode = OP_SUB; A = 32'd5; B = 32'd7;
    @(negedge clock);
    start = 1'b0;
    chk("b2b done2", 64'(done), 64'd1);
    chk("b2b lo2",   64'(Zlowout), 64'hFFFFFFFE);
    @(negedge clock);
    chk("b2b done3", 64'(done), 64'd0);

    // MUL in flight: ignored start, then reset aborts it
    start = 1'b1; opcode = OP_MUL; A = 32'd3; B = 32'd5;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 1) start = 1'b0;
      if (i == 5) begin start = 1'b1; opcode = OP_ADD; A = 32'd9; B = 32'd9; end
      if (i == 6) begin
        start = 1'b0;
        chk("busy start ignored busy", 64'(busy), 64'd1);
        chk("busy start ignored done", 64'(done), 64'd0);
      end
      if (i == 10) clear = 1'b0;
    end
    @(negedge clock);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort hi",   64'(Zhighout), 64'd0);
    chk("abort lo",   64'(Zlowout), 64'd0);
    clear = 1'b1;
    run("add wrap", OP_ADD, 32'hFFFFFFFF, 32'd1, mk(32'h0, 32'h0, 1'b0, 1));

    // 16-bit multiply
    @(negedge clock);
    s16 = 1'b1; op16 = OP_MUL; A16 = 16'hFFF9; B16 = 16'd6;
    @(negedge clock);
    s16 = 1'b0; A16 = 16'h1111; B16 = 16'h2222;
    cyc = 1; bc = 0;
    while (!done16 && cyc < 100) begin
      if (busy16) bc++;
      @(negedge clock);
      cyc++;
    end
    chk("w16 lat",  64'(cyc), 64'd17);
    chk("w16 busy", 64'(bc), 64'd16);
    chk("w16 hi",   64'(hi16), 64'hFFFF);
    chk("w16 lo",   64'(lo16), 64'hFFD6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
